// File: rtl/iob_dma_desc_sched_pkg.sv
// Shared types and helpers for the iob_dma descriptor scheduler.
package iob_dma_desc_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  localparam int DONE_CNT_W = 16;

  // Packed descriptor layout, MSB to LSB: src, dst, length, burstlen, irq_en.
  function automatic int descWidth(input int addrW, input int lengthW, input int burstW);
    return 2 * addrW + lengthW + burstW + 1;
  endfunction

endpackage

// File: rtl/iob_dma_desc_sched_if.sv
// Configuration/control bus between the descriptor scheduler and iob_dma.
interface iob_dma_desc_sched_if #(
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_LEN_W  = 8,
  parameter int LENGTH_W   = 16
);

  logic [AXI_ADDR_W-1:0] srcAddr;
  logic [AXI_ADDR_W-1:0] dstAddr;
  logic [LENGTH_W-1:0]   length;
  logic [AXI_LEN_W-1:0]  burstLen;
  logic                  start;
  logic                  softRst;
  logic                  busy;

  modport master (
    output srcAddr, dstAddr, length, burstLen, start, softRst,
    input  busy
  );

  modport slave (
    input  srcAddr, dstAddr, length, burstLen, start, softRst,
    output busy
  );

endinterface

// File: rtl/iob_dma_desc_sched_fifo.sv
// Register FIFO holding packed descriptors; the popped entry is registered
// and stays on data_o until the next pop.
module iob_dma_desc_sched_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   level_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wrPtr_q;
  logic [ADDR_W-1:0] rdPtr_q;
  logic [ADDR_W:0]   level_q;
  logic [ADDR_W:0]   level_d;
  logic [DATA_W-1:0] data_q;
  logic              doPush;
  logic              doPop;

  assign full_o  = level_q[ADDR_W];
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign data_o  = data_q;
  assign doPush  = push_i & ~full_o & ~flush_i;
  assign doPop   = pop_i & ~empty_o & ~flush_i;

  // Occupancy: a simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_d = level_q;
    if (doPush && !doPop) begin
      level_d = level_q + (ADDR_W + 1)'(1);
    end else if (doPop && !doPush) begin
      level_d = level_q - (ADDR_W + 1)'(1);
    end
  end

  // Pointers and level; flush empties the queue without touching storage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else if (cke_i) begin
      if (flush_i) begin
        wrPtr_q <= '0;
        rdPtr_q <= '0;
        level_q <= '0;
      end else begin
        if (doPush) wrPtr_q <= wrPtr_q + ADDR_W'(1);
        if (doPop)  rdPtr_q <= rdPtr_q + ADDR_W'(1);
        level_q <= level_d;
      end
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk_i) begin
    if (cke_i && doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  // Output register captures the head entry at the pop edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= '0;
    end else if (cke_i && doPop) begin
      data_q <= mem_q[rdPtr_q];
    end
  end

endmodule

// File: rtl/iob_dma_desc_sched.sv
// Descriptor scheduler in front of iob_dma: queues descriptors, issues them
// one at a time, tracks busy, counts completions and flags errors.
module iob_dma_desc_sched
  import iob_dma_desc_sched_pkg::*;
#(
  parameter int AXI_ADDR_W   = 24,
  parameter int AXI_LEN_W    = 8,
  parameter int LENGTH_W     = 16,
  parameter int DESC_DEPTH_W = 2,
  parameter int BUSY_TMO     = 15
) (
  input  logic                    clk_i,
  input  logic                    cke_i,
  input  logic                    rst_i,
  input  logic                    desc_valid_i,
  output logic                    desc_ready_o,
  input  logic [AXI_ADDR_W-1:0]   desc_src_addr_i,
  input  logic [AXI_ADDR_W-1:0]   desc_dst_addr_i,
  input  logic [LENGTH_W-1:0]     desc_length_i,
  input  logic [AXI_LEN_W-1:0]    desc_burstlen_i,
  input  logic                    desc_irq_en_i,
  iob_dma_desc_sched_if.master    dma_if,
  input  logic                    abort_i,
  input  logic                    irq_clr_i,
  output logic                    active_o,
  output logic [DESC_DEPTH_W:0]   queue_level_o,
  output logic [DONE_CNT_W-1:0]   done_cnt_o,
  output logic                    irq_o,
  output logic                    err_o
);

  localparam int DESC_W    = descWidth(AXI_ADDR_W, LENGTH_W, AXI_LEN_W);
  localparam int IRQ_OFF   = 0;
  localparam int BURST_OFF = 1;
  localparam int LEN_OFF   = BURST_OFF + AXI_LEN_W;
  localparam int DST_OFF   = LEN_OFF + LENGTH_W;
  localparam int SRC_OFF   = DST_OFF + AXI_ADDR_W;
  localparam int TMO_W     = $clog2(BUSY_TMO + 1);

  state_e                  state_q, state_d;
  logic [TMO_W-1:0]        tmoCnt_q, tmoCnt_d;
  logic [DONE_CNT_W-1:0]   doneCnt_q, doneCnt_d;
  logic                    irq_q, irq_d;
  logic                    err_q, err_d;
  logic                    softRst_q, softRst_d;
  logic [AXI_ADDR_W-1:0]   dmaSrc_q, dmaDst_q;
  logic [LENGTH_W-1:0]     dmaLen_q;
  logic [AXI_LEN_W-1:0]    dmaBurst_q;
  logic                    pop;
  logic                    loadDma;
  logic                    fifoPush;
  logic                    fifoFull;
  logic                    fifoEmpty;
  logic [DESC_W-1:0]       fifoData;

  assign desc_ready_o = ~fifoFull & ~abort_i;
  assign fifoPush     = desc_valid_i & desc_ready_o;

  iob_dma_desc_sched_fifo #(
    .DATA_W (DESC_W),
    .ADDR_W (DESC_DEPTH_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .rst_i   (rst_i),
    .flush_i (abort_i),
    .push_i  (fifoPush),
    .data_i  ({desc_src_addr_i, desc_dst_addr_i, desc_length_i, desc_burstlen_i, desc_irq_en_i}),
    .pop_i   (pop),
    .data_o  (fifoData),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .level_o (queue_level_o)
  );

  // Next-state logic; abort overrides every state and a completion set beats irq_clr_i.
  always_comb begin
    state_d   = state_q;
    tmoCnt_d  = tmoCnt_q;
    doneCnt_d = doneCnt_q;
    irq_d     = irq_q;
    err_d     = err_q;
    softRst_d = 1'b0;
    pop       = 1'b0;
    loadDma   = 1'b0;
    if (irq_clr_i) irq_d = 1'b0;
    if (abort_i) begin
      state_d   = ST_IDLE;
      softRst_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifoEmpty) begin
            pop     = 1'b1;
            state_d = ST_LOAD;
          end
        end
        ST_LOAD: begin
          loadDma = 1'b1;
          if (fifoData[LEN_OFF +: LENGTH_W] == '0) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_START;
          end
        end
        ST_START: begin
          tmoCnt_d = '0;
          state_d  = ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (dma_if.busy) begin
            state_d = ST_WAIT_DONE;
          end else if (tmoCnt_q == TMO_W'(BUSY_TMO - 1)) begin
            err_d     = 1'b1;
            softRst_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            tmoCnt_d = tmoCnt_q + TMO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!dma_if.busy) begin
            doneCnt_d = doneCnt_q + DONE_CNT_W'(1);
            if (fifoData[IRQ_OFF]) irq_d = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control state, counters and sticky flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      tmoCnt_q  <= '0;
      doneCnt_q <= '0;
      irq_q     <= 1'b0;
      err_q     <= 1'b0;
      softRst_q <= 1'b0;
    end else if (cke_i) begin
      state_q   <= state_d;
      tmoCnt_q  <= tmoCnt_d;
      doneCnt_q <= doneCnt_d;
      irq_q     <= irq_d;
      err_q     <= err_d;
      softRst_q <= softRst_d;
    end
  end

  // DMA configuration registers, held stable between LOAD states.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmaSrc_q   <= '0;
      dmaDst_q   <= '0;
      dmaLen_q   <= '0;
      dmaBurst_q <= '0;
    end else if (cke_i && loadDma) begin
      dmaSrc_q   <= fifoData[SRC_OFF +: AXI_ADDR_W];
      dmaDst_q   <= fifoData[DST_OFF +: AXI_ADDR_W];
      dmaLen_q   <= fifoData[LEN_OFF +: LENGTH_W];
      dmaBurst_q <= fifoData[BURST_OFF +: AXI_LEN_W];
    end
  end

  assign dma_if.srcAddr  = dmaSrc_q;
  assign dma_if.dstAddr  = dmaDst_q;
  assign dma_if.length   = dmaLen_q;
  assign dma_if.burstLen = dmaBurst_q;
  assign dma_if.start    = (state_q == ST_START);
  assign dma_if.softRst  = softRst_q;

  assign active_o   = (state_q != ST_IDLE);
  assign done_cnt_o = doneCnt_q;
  assign irq_o      = irq_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_iob_dma_desc_sched.sv
// Directed self-checking bench for iob_dma_desc_sched with a reactive busy model.
module tb_iob_dma_desc_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cke = 1'b1;
  logic        descValid = 1'b0;
  logic        descReady;
  logic [23:0] descSrc = '0;
  logic [23:0] descDst = '0;
  logic [15:0] descLen = '0;
  logic [7:0]  descBurst = '0;
  logic        descIrqEn = 1'b0;
  logic        abort = 1'b0;
  logic        irqClr = 1'b0;
  logic        active;
  logic [2:0]  level;
  logic [15:0] doneCnt;
  logic        irq;
  logic        err;

  int passCount = 0;
  int checkCount = 0;
  int cyc = 0;
  bit busyEnable = 1'b0;
  int busyDelay = 1;
  int busyLen = 5;
  int busyFrom = 0;
  int busyTo = 0;
  logic [23:0] startSrc[$];
  logic [15:0] startLen[$];

  iob_dma_desc_sched_if #(.AXI_ADDR_W(24), .AXI_LEN_W(8), .LENGTH_W(16)) dmaIf ();

  iob_dma_desc_sched #(
    .AXI_ADDR_W   (24),
    .AXI_LEN_W    (8),
    .LENGTH_W     (16),
    .DESC_DEPTH_W (2),
    .BUSY_TMO     (15)
  ) dut (
    .clk_i           (clk),
    .cke_i           (cke),
    .rst_i           (rst),
    .desc_valid_i    (descValid),
    .desc_ready_o    (descReady),
    .desc_src_addr_i (descSrc),
    .desc_dst_addr_i (descDst),
    .desc_length_i   (descLen),
    .desc_burstlen_i (descBurst),
    .desc_irq_en_i   (descIrqEn),
    .dma_if          (dmaIf),
    .abort_i         (abort),
    .irq_clr_i       (irqClr),
    .active_o        (active),
    .queue_level_o   (level),
    .done_cnt_o      (doneCnt),
    .irq_o           (irq),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  // Free-running cycle count used to schedule the busy window.
  always @(posedge clk) cyc <= cyc + 1;

  // DMA stand-in: logs every start and raises busy busyDelay cycles later for busyLen cycles.
  always @(negedge clk) begin
    if (dmaIf.start === 1'b1) begin
      startSrc.push_back(dmaIf.srcAddr);
      startLen.push_back(dmaIf.length);
      if (busyEnable) begin
        busyFrom = cyc + busyDelay;
        busyTo   = busyFrom + busyLen;
      end
    end
    dmaIf.busy = busyEnable && (cyc >= busyFrom) && (cyc < busyTo);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] src, input logic [23:0] dst,
                               input logic [15:0] len, input logic [7:0] burst, input logic irqEn);
    int n = 0;
    while (descReady !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("push ready", 32'(descReady), 32'(1));
    descValid = 1'b1;
    descSrc   = src;
    descDst   = dst;
    descLen   = len;
    descBurst = burst;
    descIrqEn = irqEn;
    @(negedge clk);
    descValid = 1'b0;
  endtask

  task automatic waitDone(input logic [15:0] target, input int maxCycles, input string tag);
    int n = 0;
    while (doneCnt !== target && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(doneCnt), 32'(target));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst ready", 32'(descReady), 32'(1));
    checkOutput("rst active", 32'(active), 32'(0));
    checkOutput("rst level", 32'(level), 32'(0));
    checkOutput("rst done", 32'(doneCnt), 32'(0));
    checkOutput("rst irq", 32'(irq), 32'(0));
    checkOutput("rst err", 32'(err), 32'(0));
    checkOutput("rst start", 32'(dmaIf.start), 32'(0));
    checkOutput("rst softrst", 32'(dmaIf.softRst), 32'(0));

    $display("[TB] test 1: single descriptor");
    busyEnable = 1'b1;
    busyDelay  = 1;
    busyLen    = 5;
    startSrc.delete();
    startLen.delete();
    applyStimulus(24'h000100, 24'h000200, 16'd16, 8'd4, 1'b1);
    checkOutput("t1 level after push", 32'(level), 32'(1));
    checkOutput("t1 idle after push", 32'(active), 32'(0));
    @(negedge clk);
    checkOutput("t1 active in load", 32'(active), 32'(1));
    checkOutput("t1 level after pop", 32'(level), 32'(0));
    checkOutput("t1 no early start", 32'(dmaIf.start), 32'(0));
    @(negedge clk);
    checkOutput("t1 start pulse", 32'(dmaIf.start), 32'(1));
    checkOutput("t1 src", 32'(dmaIf.srcAddr), 32'h100);
    checkOutput("t1 dst", 32'(dmaIf.dstAddr), 32'h200);
    checkOutput("t1 len", 32'(dmaIf.length), 32'd16);
    checkOutput("t1 burst", 32'(dmaIf.burstLen), 32'd4);
    @(negedge clk);
    checkOutput("t1 start one cycle", 32'(dmaIf.start), 32'(0));
    waitDone(16'd1, 100, "t1 done count");
    checkOutput("t1 start count", 32'(startSrc.size()), 32'(1));
    checkOutput("t1 irq", 32'(irq), 32'(1));
    checkOutput("t1 err", 32'(err), 32'(0));
    checkOutput("t1 idle after done", 32'(active), 32'(0));

    $display("[TB] test 2: five back-to-back descriptors");
    irqClr = 1'b1;
    @(negedge clk);
    irqClr = 1'b0;
    checkOutput("t2 irq cleared", 32'(irq), 32'(0));
    busyLen = 20;
    startSrc.delete();
    startLen.delete();
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(24'(i * 32'h1000), 24'(i * 32'h1000 + 32'h800), 16'(i), 8'd2, 1'b0);
    end
    checkOutput("t2 ready low when full", 32'(descReady), 32'(0));
    checkOutput("t2 level full", 32'(level), 32'(4));
    descValid = 1'b1;
    descSrc   = 24'hDEAD00;
    @(negedge clk);
    descValid = 1'b0;
    checkOutput("t2 push while full ignored", 32'(level), 32'(4));
    waitDone(16'd6, 600, "t2 done count");
    checkOutput("t2 start count", 32'(startSrc.size()), 32'(5));
    for (int i = 1; i <= 5; i++) begin
      checkOutput("t2 order src", 32'(startSrc[i-1]), i * 32'h1000);
      checkOutput("t2 order len", 32'(startLen[i-1]), 32'(i));
    end
    checkOutput("t2 queue drained", 32'(level), 32'(0));
    checkOutput("t2 irq stays low", 32'(irq), 32'(0));

    $display("[TB] test 3: zero-length descriptor");
    startSrc.delete();
    startLen.delete();
    applyStimulus(24'h007000, 24'h007800, 16'd0, 8'd1, 1'b1);
    applyStimulus(24'h008000, 24'h008800, 16'd8, 8'd2, 1'b0);
    waitDone(16'd7, 200, "t3 done count");
    checkOutput("t3 err", 32'(err), 32'(1));
    checkOutput("t3 start count", 32'(startSrc.size()), 32'(1));
    checkOutput("t3 started src", 32'(startSrc[0]), 32'h8000);
    checkOutput("t3 irq", 32'(irq), 32'(0));

    $display("[TB] test 4: busy timeout");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t4 err after reset", 32'(err), 32'(0));
    checkOutput("t4 done after reset", 32'(doneCnt), 32'(0));
    busyEnable = 1'b0;
    startSrc.delete();
    startLen.delete();
    applyStimulus(24'h009000, 24'h009800, 16'd4, 8'd1, 1'b1);
    repeat (17) @(negedge clk);
    checkOutput("t4 err before timeout", 32'(err), 32'(0));
    checkOutput("t4 active waiting", 32'(active), 32'(1));
    @(negedge clk);
    checkOutput("t4 err on timeout", 32'(err), 32'(1));
    checkOutput("t4 softrst pulse", 32'(dmaIf.softRst), 32'(1));
    checkOutput("t4 idle after timeout", 32'(active), 32'(0));
    @(negedge clk);
    checkOutput("t4 softrst one cycle", 32'(dmaIf.softRst), 32'(0));
    checkOutput("t4 done unchanged", 32'(doneCnt), 32'(0));
    checkOutput("t4 start count", 32'(startSrc.size()), 32'(1));

    $display("[TB] test 5: abort during transfer");
    busyEnable = 1'b1;
    busyLen    = 30;
    startSrc.delete();
    startLen.delete();
    applyStimulus(24'h00A000, 24'h00A800, 16'd4, 8'd1, 1'b1);
    applyStimulus(24'h00B000, 24'h00B800, 16'd4, 8'd1, 1'b1);
    applyStimulus(24'h00C000, 24'h00C800, 16'd4, 8'd1, 1'b1);
    applyStimulus(24'h00D000, 24'h00D800, 16'd4, 8'd1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("t5 active before abort", 32'(active), 32'(1));
    checkOutput("t5 three queued", 32'(level), 32'(3));
    abort     = 1'b1;
    descValid = 1'b1;
    descSrc   = 24'hEEEE00;
    #1;
    checkOutput("t5 ready low in abort", 32'(descReady), 32'(0));
    @(negedge clk);
    abort     = 1'b0;
    descValid = 1'b0;
    checkOutput("t5 softrst pulse", 32'(dmaIf.softRst), 32'(1));
    checkOutput("t5 queue flushed", 32'(level), 32'(0));
    checkOutput("t5 idle after abort", 32'(active), 32'(0));
    @(negedge clk);
    checkOutput("t5 softrst one cycle", 32'(dmaIf.softRst), 32'(0));
    checkOutput("t5 coincident push dropped", 32'(level), 32'(0));
    repeat (40) @(negedge clk);
    checkOutput("t5 no further starts", 32'(startSrc.size()), 32'(1));
    checkOutput("t5 done unchanged", 32'(doneCnt), 32'(0));
    checkOutput("t5 err unchanged", 32'(err), 32'(1));
    checkOutput("t5 irq unchanged", 32'(irq), 32'(0));
    checkOutput("t5 still idle", 32'(active), 32'(0));

    $display("[TB] test 6: irq set beats clear, done counter wrap");
    force dut.doneCnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.doneCnt_q;
    busyLen = 3;
    irqClr  = 1'b1;
    applyStimulus(24'h00F000, 24'h00F800, 16'd2, 8'd1, 1'b1);
    for (int n = 0; n < 100 && doneCnt === 16'hFFFF; n++) begin
      @(negedge clk);
    end
    irqClr = 1'b0;
    checkOutput("t6 done wraps", 32'(doneCnt), 32'(0));
    checkOutput("t6 irq set wins", 32'(irq), 32'(1));
    irqClr = 1'b1;
    @(negedge clk);
    irqClr = 1'b0;
    checkOutput("t6 irq clear", 32'(irq), 32'(0));
    checkOutput("t6 done stable", 32'(doneCnt), 32'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
